sha3_absorb_sequencer: RTL and testbench
========================================

# sha3_absorb_sequencer

Controller that sequences one SHA3 message from the 64-bit read side of the bus FIFO into the Keccak core. It resets the core and feeds message words with the core's `in_ready`/`is_last`/`byte_num` protocol, throttled by `buffer_full`. It then captures the 512-bit digest on `out_ready` and reports completion. It sits between `Bus_FIFO` (read port) and the Keccak core, replacing ad-hoc fill logic in the datapath FSM.

## Interface
- `LEN_W`, default 32: width of the message length in bytes.
- `clk`  input  1  clock.
- `reset`  input  1  synchronous, active-high.
- `start`  input  1  begin a message; sampled only in IDLE.
- `msg_len`  input  LEN_W  message length in bytes; latched on accepted `start`.
- `fifo_empty`  input  1  FIFO read side has no 64-bit word.
- `fifo_read_en`  output  1  one-cycle read strobe.
- `fifo_read_data`  input  64  valid the cycle after `fifo_read_en`.
- `keccak_rst`  output  1  one-cycle reset pulse to the core.
- `keccak_input`  output  64  word presented to the core (registered).
- `in_ready`  output  1  word valid to the core.
- `is_last`  output  1  qualifies the final word.
- `byte_num`  output  3  valid bytes in the final word (0..7).
- `buffer_full`  input  1  core cannot accept a word.
- `out_ready`  input  1  core digest valid.
- `hash_in`  input  512  core digest.
- `keccak_hash_reg`  output  512  captured digest.
- `busy`  output  1  high outside IDLE.
- `done`  output  1  one-cycle completion pulse.

## Operation
- Reset values:
  - State IDLE.
  - All strobes 0.
  - `keccak_input` = 0, `byte_num` = 0.
  - `keccak_hash_reg` = 0.
  - `busy` = 0, `done` = 0.
  - Counters 0.
- On accepted `start`:
  - Latch `full_words = msg_len >> 3` and `rem = msg_len[2:0]`.
  - `fetch_words = full_words + (rem != 0)`.
- Last-word rule:
  - If `rem != 0`, the last fetched word is sent with `is_last = 1` and `byte_num = rem`.
  - If `rem == 0`, after all words a pad word `keccak_input = 0` is sent with `is_last = 1` and `byte_num = 0`; it involves no FIFO read.
  - `msg_len = 0` sends only the pad word.
- Bytes are consumed MSB first; unused low bytes of a partial word pass through unchanged.
- States:
  - IDLE: `start` -> CLR.
  - CLR: `keccak_rst = 1` for one cycle. Then FETCH if `fetch_words > 0`, else PAD.
  - FETCH: when `~fifo_empty`, assert `fifo_read_en` for one cycle, decrement the remaining count -> DATA. Otherwise hold with no strobe.
  - DATA: latch `fifo_read_data` into `keccak_input`. Set `is_last`/`byte_num` if this is the final fetched word with `rem != 0` -> SEND.
  - PAD: load `keccak_input = 0`, `is_last = 1`, `byte_num = 0` -> SEND.
  - SEND: `in_ready = ~buffer_full`, combinational. On a cycle with `in_ready = 1`:
    - -> WAIT_HASH if `is_last`.
    - Else -> FETCH if words remain.
    - Else -> PAD.
  - WAIT_HASH: on `out_ready`, capture `hash_in` into `keccak_hash_reg` -> DONE.
  - DONE: `done = 1` for one cycle -> IDLE.
- `is_last` and `byte_num` are meaningful only while `in_ready = 1`. They are cleared to 0 when leaving SEND.
- `start` outside IDLE is ignored. `msg_len` changes after acceptance have no effect.
- `keccak_hash_reg` holds its value until the next capture; `start` does not clear it.
- Reset in any state returns to IDLE with all reset values, including mid-SEND and mid-WAIT_HASH. The core is reset via the next CLR.
- `out_ready` outside WAIT_HASH is ignored.

## Timing
- `start` at cycle 0 -> `keccak_rst` at cycle 1 -> first `fifo_read_en` at cycle 2 (FIFO non-empty).
- Unstalled throughput: one word per 3 cycles (FETCH, DATA, SEND).
- `keccak_input` is stable from DATA/PAD through the accepting SEND cycle.
- `buffer_full = 1` in SEND stalls indefinitely with `keccak_input`, `is_last` and `byte_num` held.
- `fifo_empty = 1` stalls in FETCH indefinitely.
- `done` asserts the cycle after `out_ready` is sampled in WAIT_HASH. `keccak_hash_reg` is valid in that same cycle.
- `busy` is high from the cycle after accepted `start` through the DONE cycle.

## Test plan
- `msg_len = 0`: no `fifo_read_en`; exactly one `in_ready` with `keccak_input = 0`, `is_last = 1`, `byte_num = 0`; `hash_in` captured on `out_ready`; `done` pulses once.
- `msg_len = 16`, FIFO words A, B: 2 reads; `in_ready` with A, then with B (`is_last = 0`); then pad word with `is_last = 1`, `byte_num = 0`.
- `msg_len = 13`, words A, B: 2 reads; second `in_ready` carries B with `is_last = 1`, `byte_num = 5`; no pad word.
- `buffer_full` high for 10 cycles in SEND: `in_ready = 0` throughout, outputs held; word accepted on the first low cycle; word count unchanged.
- FIFO empty for 20 cycles mid-message, and `start` pulsed while busy: no read strobe while empty; second `start` ignored; exactly `fetch_words` reads total.
- Reset asserted during WAIT_HASH: next cycle IDLE, `busy = 0`, `keccak_hash_reg = 0`; later `out_ready` ignored; new `start` gives `keccak_rst` at the next cycle.

Source files
------------

// File: rtl/sha3_absorb_sequencer_if.sv
// Bus between the absorb sequencer, the FIFO read port and the Keccak core.
// master = sequencer side, slave = FIFO/core/host environment side.
interface sha3_absorb_sequencer_if #(
    parameter int LEN_W = 32
);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             fifo_empty;
    logic             fifo_read_en;
    logic [63:0]      fifo_read_data;
    logic             keccak_rst;
    logic [63:0]      keccak_input;
    logic             in_ready;
    logic             is_last;
    logic [2:0]       byte_num;
    logic             buffer_full;
    logic             out_ready;
    logic [511:0]     hash_in;
    logic [511:0]     keccak_hash_reg;
    logic             busy;
    logic             done;

    modport master (
        input  start, msg_len, fifo_empty, fifo_read_data, buffer_full, out_ready, hash_in,
        output fifo_read_en, keccak_rst, keccak_input, in_ready, is_last, byte_num,
               keccak_hash_reg, busy, done
    );

    modport slave (
        output start, msg_len, fifo_empty, fifo_read_data, buffer_full, out_ready, hash_in,
        input  fifo_read_en, keccak_rst, keccak_input, in_ready, is_last, byte_num,
               keccak_hash_reg, busy, done
    );
endinterface

// File: rtl/sha3_absorb_sequencer.sv
// Sequences one message from the 64-bit FIFO read port into the Keccak core,
// appending a zero pad word when the length is a multiple of 8 bytes.
module sha3_absorb_sequencer #(
    parameter int LEN_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    sha3_absorb_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CLR, FETCH, DATA, PAD, SEND, WAIT_HASH, DONE
    } state_t;

    state_t           state_reg;
    logic [LEN_W-1:0] words_left_reg;
    logic [2:0]       rem_reg;
    logic             keccak_rst_reg;
    logic [63:0]      keccak_input_reg;
    logic             is_last_reg;
    logic [2:0]       byte_num_reg;
    logic [511:0]     hash_capture_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [LEN_W-1:0] fetch_words_next;
    logic             read_fire;
    logic             send_fire;

    // Whole words plus one extra fetch for a partial tail.
    assign fetch_words_next = (bus.msg_len >> 3) + {{(LEN_W-1){1'b0}}, |bus.msg_len[2:0]};

    // Read strobe and word-valid depend on same-cycle FIFO/core status.
    assign read_fire = (state_reg == FETCH) && !bus.fifo_empty;
    assign send_fire = (state_reg == SEND) && !bus.buffer_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            words_left_reg   <= '0;
            rem_reg          <= '0;
            keccak_rst_reg   <= 1'b0;
            keccak_input_reg <= '0;
            is_last_reg      <= 1'b0;
            byte_num_reg     <= '0;
            hash_capture_reg <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        words_left_reg <= fetch_words_next;
                        rem_reg        <= bus.msg_len[2:0];
                        keccak_rst_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= CLR;
                    end
                end
                CLR: begin
                    keccak_rst_reg <= 1'b0;
                    state_reg      <= (words_left_reg != '0) ? FETCH : PAD;
                end
                FETCH: begin
                    if (read_fire) begin
                        words_left_reg <= words_left_reg - 1'b1;
                        state_reg      <= DATA;
                    end
                end
                DATA: begin
                    keccak_input_reg <= bus.fifo_read_data;
                    // A partial tail word closes the message; no pad follows.
                    if (words_left_reg == '0 && rem_reg != 3'd0) begin
                        is_last_reg  <= 1'b1;
                        byte_num_reg <= rem_reg;
                    end
                    state_reg <= SEND;
                end
                PAD: begin
                    keccak_input_reg <= '0;
                    is_last_reg      <= 1'b1;
                    byte_num_reg     <= 3'd0;
                    state_reg        <= SEND;
                end
                SEND: begin
                    if (send_fire) begin
                        is_last_reg  <= 1'b0;
                        byte_num_reg <= 3'd0;
                        if (is_last_reg)
                            state_reg <= WAIT_HASH;
                        else if (words_left_reg != '0)
                            state_reg <= FETCH;
                        else
                            state_reg <= PAD;
                    end
                end
                WAIT_HASH: begin
                    if (bus.out_ready) begin
                        hash_capture_reg <= bus.hash_in;
                        done_reg         <= 1'b1;
                        state_reg        <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.fifo_read_en    = read_fire;
    assign bus.in_ready        = send_fire;
    assign bus.keccak_rst      = keccak_rst_reg;
    assign bus.keccak_input    = keccak_input_reg;
    assign bus.is_last         = is_last_reg;
    assign bus.byte_num        = byte_num_reg;
    assign bus.keccak_hash_reg = hash_capture_reg;
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
endmodule

// File: tb/tb_sha3_absorb_sequencer.sv
// Directed bench for sha3_absorb_sequencer: FIFO model, word scoreboard and
// per-message read/done/core-reset accounting.
module tb_sha3_absorb_sequencer;
    logic clk;
    logic reset;

    sha3_absorb_sequencer_if #(.LEN_W(32)) bus ();

    sha3_absorb_sequencer #(.LEN_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [2:0]  b;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] fifo_mem[16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          reads = 0;
    int          done_cnt = 0;
    int          rst_cnt = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples outputs mid-cycle, then advances one clock and services the FIFO.
    task automatic tick();
        logic rd_now;
        exp_t e;
        #1;
        rd_now = bus.fifo_read_en;
        if (rd_now) reads++;
        if (bus.done) done_cnt++;
        if (bus.keccak_rst) rst_cnt++;
        if (bus.in_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {bus.keccak_input, bus.is_last, bus.byte_num}, 576'h0 - 1);
            end else begin
                e = sb.pop_front();
                check("word", {bus.keccak_input, bus.is_last, bus.byte_num}, e);
            end
        end
        @(posedge clk);
        #1;
        if (rd_now) begin
            bus.fifo_read_data = fifo_mem[rd_ptr % 16];
            rd_ptr++;
        end
    endtask

    task automatic push_word(input logic [63:0] w, input logic l, input logic [2:0] b, input bit from_fifo);
        if (from_fifo) begin
            fifo_mem[wr_ptr % 16] = w;
            wr_ptr++;
        end
        sb.push_back({w, l, b});
    endtask

    task automatic begin_msg(input logic [31:0] len);
        reads = 0;
        done_cnt = 0;
        rst_cnt = 0;
        bus.msg_len = len;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.msg_len = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input logic [511:0] h, input int exp_reads);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            if (sb.size() == 0) begin
                bus.out_ready = 1'b1;
                bus.hash_in = h;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("done_seen", done_cnt, 1);
        check("hash_captured", bus.keccak_hash_reg, h);
        check("busy_after_done", bus.busy, 0);
        tick();
        check("done_once", done_cnt, 1);
        check("fifo_reads", reads, exp_reads);
        check("sb_drained", sb.size(), 0);
        check("core_reset_once", rst_cnt, 1);
    endtask

    task automatic wait_input(input logic [63:0] w);
        int cyc = 0;
        while (bus.keccak_input !== w && cyc < 100) begin
            tick();
            cyc++;
        end
        check("reach_send", bus.keccak_input, w);
    endtask

    logic [511:0] h;
    logic [63:0]  wa, wb, wc;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.msg_len = '0;
        bus.fifo_read_data = '0;
        bus.buffer_full = 1'b0;
        bus.out_ready = 1'b0;
        bus.hash_in = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hash", bus.keccak_hash_reg, 0);
        check("rst_strobes", {bus.fifo_read_en, bus.keccak_rst, bus.in_ready, bus.is_last}, 0);
        check("rst_input", {bus.keccak_input, bus.byte_num}, 0);

        // Empty message: pad word only, no FIFO reads.
        push_word(64'h0, 1'b1, 3'd0, 1'b0);
        h = {16{$urandom}};
        begin_msg(32'd0);
        check("len0_core_reset", bus.keccak_rst, 1);
        check("len0_busy", bus.busy, 1);
        wait_done(h, 0);
        $display("len0 message done, reads=%0d", reads);

        // 16 bytes: two full words then a pad word; checks start-to-read latency.
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        push_word(wa, 1'b0, 3'd0, 1'b1);
        push_word(wb, 1'b0, 3'd0, 1'b1);
        push_word(64'h0, 1'b1, 3'd0, 1'b0);
        h = {16{$urandom}};
        begin_msg(32'd16);
        check("len16_core_reset_c1", bus.keccak_rst, 1);
        tick();
        check("len16_read_c2", bus.fifo_read_en, 1);
        wait_done(h, 2);
        $display("len16 message done, reads=%0d", reads);

        // 13 bytes with buffer_full stalls: second word carries is_last/byte_num=5.
        wa = {$urandom, $urandom} | 64'h1;
        wb = {$urandom, $urandom} | 64'h2;
        push_word(wa, 1'b0, 3'd0, 1'b1);
        push_word(wb, 1'b1, 3'd5, 1'b1);
        h = {16{$urandom}};
        begin_msg(32'd13);
        bus.buffer_full = 1'b1;
        wait_input(wa);
        bus.buffer_full = 1'b0;
        tick();
        bus.buffer_full = 1'b1;
        wait_input(wb);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_held", {bus.keccak_input, bus.is_last, bus.byte_num}, {wb, 1'b1, 3'd5});
            tick();
        end
        check("stall_sb_pending", sb.size(), 1);
        bus.buffer_full = 1'b0;
        wait_done(h, 2);
        $display("len13 stalled message done, reads=%0d", reads);

        // 24 bytes, FIFO held empty mid-message, start pulsed while busy.
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        wc = {$urandom, $urandom};
        push_word(wa, 1'b0, 3'd0, 1'b1);
        push_word(wb, 1'b0, 3'd0, 1'b1);
        push_word(wc, 1'b0, 3'd0, 1'b1);
        push_word(64'h0, 1'b1, 3'd0, 1'b0);
        h = {16{$urandom}};
        begin_msg(32'd24);
        for (int i = 0; i < 50 && reads == 0; i++) tick();
        hold_empty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) bus.start = 1'b1;
            if (i == 6) bus.start = 1'b0;
            #1;
            check("empty_no_read", bus.fifo_read_en, 0);
            tick();
        end
        hold_empty = 1'b0;
        wait_done(h, 3);
        tick();
        check("no_restart", bus.busy, 0);
        $display("len24 empty-stall message done, reads=%0d", reads);

        // Reset in WAIT_HASH clears digest; later out_ready ignored.
        push_word(64'h0, 1'b1, 3'd0, 1'b0);
        begin_msg(32'd0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_busy", bus.busy, 0);
        check("rst_wait_hash", bus.keccak_hash_reg, 0);
        bus.out_ready = 1'b1;
        bus.hash_in = {16{32'hDEAD_BEEF}};
        done_cnt = 0;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        check("ignored_out_ready_done", done_cnt, 0);
        check("ignored_out_ready_hash", bus.keccak_hash_reg, 0);
        push_word(64'h0, 1'b1, 3'd0, 1'b0);
        h = {16{$urandom}};
        begin_msg(32'd0);
        check("restart_core_reset", bus.keccak_rst, 1);
        wait_done(h, 0);
        $display("reset-during-wait sequence done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
